// File: rtl/flash_boot_loader_pkg.sv
// Shared types and constants for the flash-to-SRAM boot loader.
package flash_boot_loader_pkg;

  localparam int unsigned FLASH_ADDR_W = 24;
  localparam int unsigned SRAM_ADDR_W  = 20;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned WAIT_W       = 4;

  typedef logic [FLASH_ADDR_W-1:0] Flash_addr_t;
  typedef logic [WORD_W-1:0]       Word_t;
  typedef logic [SRAM_ADDR_W-1:0]  Sram_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ_REQ  = 3'd1,
    ST_READ_WAIT = 3'd2,
    ST_WRITE     = 3'd3,
    ST_DONE      = 3'd4
  } loader_state_e;

  // Word counter must hold the value LOAD_WORDS itself (final compare), never wrap.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/flash_boot_loader.sv
// Boot-time copier: reads LOAD_WORDS words from flash and writes them to SRAM.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start
// READ_REQ   | first read_op cycle, flash address presented
// READ_WAIT  | read_op held until the wait counter reaches 0, then capture
// WRITE      | sram_we held with address/data until sram_ack
// DONE       | copy complete, terminal until reset
module flash_boot_loader
  import flash_boot_loader_pkg::*;
#(
  parameter int unsigned LOAD_WORDS = 16,
  parameter int unsigned FLASH_BASE = 0,
  parameter int unsigned SRAM_BASE  = 0,
  parameter int unsigned FLASH_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output Flash_addr_t            bus_addr,
  output logic                   read_op,
  input  Word_t                  bus_data,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output Word_t                  sram_wdata,
  output logic                   sram_we,
  input  logic                   sram_ack,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CNT_W = cnt_width(LOAD_WORDS);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t              LAST_CNT  = cnt_t'(LOAD_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(FLASH_WAIT - 1);

  loader_state_e     state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  Word_t             data_q, data_d;
  cnt_t              cnt_inc;

  assign cnt_inc = cnt_q + cnt_t'(1);

  // State, counters and captured word; reset abandons any copy in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic. The wait counter is loaded on entry to READ_REQ and counts
  // down through READ_REQ/READ_WAIT, so capture lands on the FLASH_WAIT-th read_op
  // cycle; with FLASH_WAIT=1 the capture happens in READ_REQ itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          wcnt_d  = WAIT_LOAD;
          state_d = (LOAD_WORDS == 0) ? ST_DONE : ST_READ_REQ;
        end
      end
      ST_READ_REQ, ST_READ_WAIT: begin
        if (wcnt_q == '0) begin
          data_d  = bus_data;
          state_d = ST_WRITE;
        end else begin
          wcnt_d  = wcnt_q - WAIT_W'(1);
          state_d = ST_READ_WAIT;
        end
      end
      ST_WRITE: begin
        if (sram_ack) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            wcnt_d  = WAIT_LOAD;
            state_d = ST_READ_REQ;
          end
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from state only, so reset clears them in the same cycle and
  // address/data stay frozen while a request is held.
  always_comb begin
    read_op    = (state_q == ST_READ_REQ) || (state_q == ST_READ_WAIT);
    sram_we    = (state_q == ST_WRITE);
    busy       = read_op || sram_we;
    done       = (state_q == ST_DONE);
    bus_addr   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (read_op) begin
      bus_addr = Flash_addr_t'(FLASH_BASE) + (Flash_addr_t'(cnt_q) << 2);
    end
    if (sram_we) begin
      sram_addr  = Sram_addr_t'(SRAM_BASE) + Sram_addr_t'(cnt_q);
      sram_wdata = data_q;
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Scoreboard bench for flash_boot_loader: a 4-word instance with a timed flash
// model and a randomly back-pressuring SRAM, plus a LOAD_WORDS=0 instance.
module tb_flash_boot_loader;
  import flash_boot_loader_pkg::*;

  localparam int unsigned LW = 4;
  localparam int unsigned FW = 4;
  localparam int unsigned FB = 0;
  localparam int unsigned SB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, read_op_a, sram_we_a, sram_ack_a, busy_a, done_a;
  Flash_addr_t bus_addr_a;
  Word_t       bus_data_a, sram_wdata_a;
  logic [19:0] sram_addr_a;

  logic        rst_z, start_z, read_op_z, sram_we_z, sram_ack_z, busy_z, done_z;
  Flash_addr_t bus_addr_z;
  Word_t       bus_data_z, sram_wdata_z;
  logic [19:0] sram_addr_z;

  flash_boot_loader #(.LOAD_WORDS(LW), .FLASH_BASE(FB), .SRAM_BASE(SB), .FLASH_WAIT(FW)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .bus_addr(bus_addr_a), .read_op(read_op_a),
    .bus_data(bus_data_a), .sram_addr(sram_addr_a), .sram_wdata(sram_wdata_a),
    .sram_we(sram_we_a), .sram_ack(sram_ack_a), .busy(busy_a), .done(done_a));

  flash_boot_loader #(.LOAD_WORDS(0), .FLASH_BASE(0), .SRAM_BASE(0), .FLASH_WAIT(4)) dut_z (
    .clk(clk), .rst(rst_z), .start(start_z), .bus_addr(bus_addr_z), .read_op(read_op_z),
    .bus_data(bus_data_z), .sram_addr(sram_addr_z), .sram_wdata(sram_wdata_z),
    .sram_we(sram_we_z), .sram_ack(sram_ack_z), .busy(busy_z), .done(done_z));

  typedef struct packed {
    logic [19:0] addr;
    Word_t       data;
  } wr_t;

  wr_t   exp_q[$];
  Word_t flash[16];
  int    checks = 0;
  int    errors = 0;

  // Flash / SRAM model state (owned by the negedge model process)
  int          rc = 0, ridx = 0, wc = 0, wdel = 0, widx = 0;
  int          force_w = -1;
  logic [19:0] w_addr0;
  Word_t       w_data0;
  bit          z_req = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Flash reader and SRAM responder; data is only valid on the FW-th read_op cycle.
  always @(negedge clk) begin
    if (!rst_a) begin
      rc = 0; ridx = 0; wc = 0; widx = 0;
      sram_ack_a = 1'b0;
      bus_data_a = $urandom;
    end else begin
      if (read_op_a) begin
        int idx;
        rc++;
        chk(bus_addr_a == Flash_addr_t'(FB + 4 * ridx), "bus_addr", bus_addr_a, FB + 4 * ridx);
        idx = int'(bus_addr_a >> 2);
        bus_data_a = (rc == FW && idx < 16) ? flash[idx] : $urandom;
      end else begin
        if (rc != 0) begin
          chk(rc == FW, "read_op_len", rc, FW);
          ridx++;
        end
        rc = 0;
        bus_data_a = $urandom;
      end
      if (sram_we_a) begin
        wc++;
        if (wc == 1) begin
          wdel    = (widx == force_w) ? 3 : int'($urandom_range(0, 2));
          w_addr0 = sram_addr_a;
          w_data0 = sram_wdata_a;
        end else begin
          chk(sram_addr_a == w_addr0, "sram_addr_stable", sram_addr_a, w_addr0);
          chk(sram_wdata_a == w_data0, "sram_wdata_stable", sram_wdata_a, w_data0);
        end
        sram_ack_a = (wc == wdel + 1);
      end else begin
        if (wc != 0) begin
          chk(wc == wdel + 1, "sram_we_len", wc, wdel + 1);
          widx++;
        end
        wc = 0;
        sram_ack_a = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Scoreboard monitor: every accepted SRAM write pops one expected entry.
  always begin
    @(negedge clk);
    #2;
    if (rst_a) begin
      chk(!(read_op_a && sram_we_a), "req_exclusive", {read_op_a, sram_we_a}, 0);
      if (sram_we_a && sram_ack_a) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_write", sram_addr_a, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk(sram_addr_a == e.addr, "write_addr", sram_addr_a, e.addr);
          chk(sram_wdata_a == e.data, "write_data", sram_wdata_a, e.data);
        end
      end
    end
    if (rst_z && (read_op_z || sram_we_z)) z_req = 1'b1;
  end

  task automatic check_outputs_zero(input string tag);
    chk(read_op_a == 0, {tag, "_read_op"}, read_op_a, 0);
    chk(sram_we_a == 0, {tag, "_sram_we"}, sram_we_a, 0);
    chk(busy_a == 0, {tag, "_busy"}, busy_a, 0);
    chk(done_a == 0, {tag, "_done"}, done_a, 0);
    chk(bus_addr_a == 0, {tag, "_bus_addr"}, bus_addr_a, 0);
    chk(sram_addr_a == 0, {tag, "_sram_addr"}, sram_addr_a, 0);
    chk(sram_wdata_a == 0, {tag, "_sram_wdata"}, sram_wdata_a, 0);
  endtask

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(done_a == 1, "done_timeout", done_a, 1);
  endtask

  task automatic reset_a();
    @(negedge clk) rst_a = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic run_copy(input bit poke);
    for (int i = 0; i < int'(LW); i++) exp_q.push_back('{addr: 20'(SB + i), data: flash[i]});
    pulse_start_a();
    chk(busy_a == 1, "busy_after_start", busy_a, 1);
    chk(read_op_a == 1, "read_op_after_start", read_op_a, 1);
    if (poke) begin
      repeat (6) @(negedge clk);
      chk(busy_a == 1, "busy_mid_copy", busy_a, 1);
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
    end
    wait_done(400);
    chk(busy_a == 0, "busy_at_done", busy_a, 0);
    chk(exp_q.size() == 0, "missing_writes", exp_q.size(), 0);
    chk(ridx == int'(LW), "read_count", ridx, LW);
    pulse_start_a();
    repeat (20) @(negedge clk);
    chk(done_a == 1, "done_sticky", done_a, 1);
    chk(ridx == int'(LW), "no_read_after_done", ridx, LW);
    chk(!read_op_a && !sram_we_a, "idle_reqs_in_done", {read_op_a, sram_we_a}, 0);
  endtask

  initial begin
    bit hit;
    rst_a = 1'b0; rst_z = 1'b0; start_a = 1'b0; start_z = 1'b0;
    bus_data_z = '0; sram_ack_z = 1'b0;
    #1;
    check_outputs_zero("reset");
    chk(done_z == 0 && busy_z == 0, "z_reset", {done_z, busy_z}, 0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_z = 1'b1;
    repeat (3) @(negedge clk);
    chk(busy_a == 0 && done_a == 0, "idle_no_start", {busy_a, done_a}, 0);

    // Basic copy with a 3-cycle ack delay on word 2
    for (int i = 0; i < 16; i++) flash[i] = 32'hA5A5_0000 + 32'(i);
    force_w = 2;
    run_copy(1'b1);
    force_w = -1;

    // LOAD_WORDS = 0: DONE one cycle after start, never a request
    chk(done_z == 0 && busy_z == 0, "z_idle", {done_z, busy_z}, 0);
    @(negedge clk) start_z = 1'b1;
    @(negedge clk) start_z = 1'b0;
    chk(done_z == 1, "z_done_one_cycle", done_z, 1);
    chk(busy_z == 0, "z_not_busy", busy_z, 0);
    @(negedge clk) start_z = 1'b1;
    repeat (5) @(negedge clk);
    start_z = 1'b0;
    chk(done_z == 1, "z_done_sticky", done_z, 1);
    #3;
    chk(z_req == 0, "z_no_requests", z_req, 0);

    // Reset during READ_WAIT of word 1, then recopy from word 0
    reset_a();
    for (int i = 0; i < 16; i++) flash[i] = $urandom;
    for (int i = 0; i < int'(LW); i++) exp_q.push_back('{addr: 20'(SB + i), data: flash[i]});
    pulse_start_a();
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      #1;
      if (ridx == 1 && rc == 2) hit = 1'b1;
    end
    chk(hit, "reach_word1_wait", hit, 1);
    rst_a = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    chk(busy_a == 0 && done_a == 0, "wait_after_reset", {busy_a, done_a}, 0);
    run_copy(1'b0);

    // Randomized copies
    for (int r = 0; r < 3; r++) begin
      reset_a();
      for (int i = 0; i < 16; i++) flash[i] = $urandom;
      run_copy(r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
